// File: rtl/i2c_xfer_seq.sv
// I2C master transfer sequencer: expands one write / read / write-then-read /
// probe request into START, address, R/W, data, ACK and STOP bit-layer commands.
module i2c_xfer_seq #(
    parameter int ADDR_SZ = 7,
    parameter int WORD_SZ = 8,
    parameter int DATA_SZ = 4,
    parameter int CMD_SZ  = 3,
    parameter int PTR_SZ  = $clog2(DATA_SZ) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [ADDR_SZ-1:0] addr,
    input  logic [PTR_SZ-1:0]  wr_len,
    input  logic [PTR_SZ-1:0]  rd_len,
    input  logic [WORD_SZ-1:0] wr_data,
    output logic [PTR_SZ-1:0]  wr_ptr,
    output logic [WORD_SZ-1:0] rd_data,
    output logic [PTR_SZ-1:0]  rd_ptr,
    output logic               rd_we,
    output logic [CMD_SZ-1:0]  command,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    input  logic               rx_valid,
    input  logic               rx_bit,
    output logic               ready,
    output logic               nack_err
);

    // bit-layer command codes
    localparam logic [CMD_SZ-1:0] CMDIDLE  = CMD_SZ'(0);
    localparam logic [CMD_SZ-1:0] CMDSTART = CMD_SZ'(1);
    localparam logic [CMD_SZ-1:0] CMDSTOP  = CMD_SZ'(2);
    localparam logic [CMD_SZ-1:0] CMDBIT0  = CMD_SZ'(3);
    localparam logic [CMD_SZ-1:0] CMDBIT1  = CMD_SZ'(4);
    localparam logic [CMD_SZ-1:0] CMDRBIT  = CMD_SZ'(5);

    localparam int CNT_MAX = (ADDR_SZ > WORD_SZ) ? ADDR_SZ : WORD_SZ;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0]     A_LAST  = CW'(ADDR_SZ - 1);
    localparam logic [CW-1:0]     W_LAST  = CW'(WORD_SZ - 1);
    localparam logic [PTR_SZ-1:0] LEN_MAX = PTR_SZ'(DATA_SZ);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_RWBIT, S_AACK, S_WBYTE,
        S_WACK, S_RSTART, S_RBYTE, S_MACK, S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                wait_q, wait_d;        // CMDRBIT sent, waiting for rx_valid
    logic                rd_phase_q, rd_phase_d;
    logic [ADDR_SZ-1:0]  addr_q, addr_d;
    logic [PTR_SZ-1:0]   wr_len_q, wr_len_d;
    logic [PTR_SZ-1:0]   rd_len_q, rd_len_d;
    logic [PTR_SZ-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_SZ-1:0]   rd_ptr_q, rd_ptr_d;
    logic [WORD_SZ-1:0]  rd_data_q, rd_data_d;
    logic                rd_we_q, rd_we_d;
    logic [CMD_SZ-1:0]   command_q, command_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                ready_q, ready_d;
    logic                nack_err_q, nack_err_d;

    logic                load, hold;
    logic [PTR_SZ-1:0]   wl_c, rl_c, wr_ptr_inc;
    logic                last_rd;
    logic [ADDR_SZ-1:0]  a_sh;
    logic [WORD_SZ-1:0]  w_sh;
    logic [CMD_SZ-1:0]   cmd_sel;

    assign wl_c       = (wr_len > LEN_MAX) ? LEN_MAX : wr_len;
    assign rl_c       = (rd_len > LEN_MAX) ? LEN_MAX : rd_len;
    assign wr_ptr_inc = wr_ptr_q + PTR_SZ'(1);
    assign last_rd    = (rd_ptr_q == rd_len_q - PTR_SZ'(1));

    // Sequencing: accept, command handshake advance, and ACK/read-bit handling.
    // After an rx_valid event no command is loaded that cycle; the next cycle
    // loads it, so a write byte always sees wr_data at the updated wr_ptr.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        rd_phase_d = rd_phase_q;
        addr_d     = addr_q;
        wr_len_d   = wr_len_q;
        rd_len_d   = rd_len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_we_d    = 1'b0;
        ready_d    = ready_q;
        nack_err_d = nack_err_q;
        load       = 1'b0;
        hold       = 1'b0;
        if (state_q == S_IDLE) begin
            ready_d = 1'b1;
            if (init) begin
                addr_d     = addr;
                wr_len_d   = wl_c;
                rd_len_d   = rl_c;
                rd_phase_d = (wl_c == '0) && (rl_c != '0);
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                nack_err_d = 1'b0;
                ready_d    = 1'b0;
                cnt_d      = '0;
                wait_d     = 1'b0;
                state_d    = S_START;
                load       = 1'b1;
            end
        end else if (wait_q) begin
            if (rx_valid) begin
                wait_d = 1'b0;
                cnt_d  = '0;
                case (state_q)
                    S_AACK: begin
                        if (rx_bit) begin
                            nack_err_d = 1'b1;
                            state_d    = S_STOP;
                        end else if (rd_phase_q) begin
                            state_d = S_RBYTE;
                        end else if (wr_len_q != '0) begin
                            state_d = S_WBYTE;
                        end else begin
                            state_d = S_STOP;
                        end
                    end
                    S_WACK: begin
                        if (rx_bit) begin
                            nack_err_d = 1'b1;
                            state_d    = S_STOP;
                        end else begin
                            wr_ptr_d = wr_ptr_inc;
                            if (wr_ptr_inc < wr_len_q)  state_d = S_WBYTE;
                            else if (rd_len_q != '0)    state_d = S_RSTART;
                            else                        state_d = S_STOP;
                        end
                    end
                    S_RBYTE: begin
                        rd_data_d = {rd_data_q[WORD_SZ-2:0], rx_bit};
                        if (cnt_q == W_LAST) begin
                            rd_we_d = 1'b1;
                            state_d = S_MACK;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: state_d = S_STOP;
                endcase
            end
        end else if (!cmd_valid_q) begin
            load = 1'b1;
        end else if (!cmd_ready) begin
            load = 1'b1;
            hold = 1'b1;
        end else begin
            load = 1'b1;
            case (state_q)
                S_START: begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end
                S_ADDR: begin
                    if (cnt_q == A_LAST) state_d = S_RWBIT;
                    else                 cnt_d   = cnt_q + CW'(1);
                end
                S_RWBIT: state_d = S_AACK;
                S_WBYTE: begin
                    if (cnt_q == W_LAST) begin
                        state_d = S_WACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RSTART: begin
                    state_d    = S_ADDR;
                    cnt_d      = '0;
                    rd_phase_d = 1'b1;
                end
                S_MACK: begin
                    rd_ptr_d = rd_ptr_q + PTR_SZ'(1);
                    cnt_d    = '0;
                    state_d  = last_rd ? S_STOP : S_RBYTE;
                end
                S_AACK, S_WACK, S_RBYTE: begin
                    load   = 1'b0;
                    wait_d = 1'b1;
                end
                S_STOP: begin
                    load    = 1'b0;
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
                default: load = 1'b0;
            endcase
        end
    end

    // Command for the state/bit being entered; held unchanged while stalled.
    always_comb begin
        a_sh    = addr_q << cnt_d;
        w_sh    = wr_data << cnt_d;
        cmd_sel = CMDIDLE;
        case (state_d)
            S_START, S_RSTART:       cmd_sel = CMDSTART;
            S_ADDR:                  cmd_sel = a_sh[ADDR_SZ-1] ? CMDBIT1 : CMDBIT0;
            S_RWBIT:                 cmd_sel = rd_phase_q ? CMDBIT1 : CMDBIT0;
            S_AACK, S_WACK, S_RBYTE: cmd_sel = CMDRBIT;
            S_WBYTE:                 cmd_sel = w_sh[WORD_SZ-1] ? CMDBIT1 : CMDBIT0;
            S_MACK:                  cmd_sel = last_rd ? CMDBIT1 : CMDBIT0;
            S_STOP:                  cmd_sel = CMDSTOP;
            default:                 cmd_sel = CMDIDLE;
        endcase
        cmd_valid_d = load;
        command_d   = hold ? command_q : (load ? cmd_sel : CMDIDLE);
    end

    // State and registered outputs; reset drops everything without a STOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wait_q      <= 1'b0;
            rd_phase_q  <= 1'b0;
            addr_q      <= '0;
            wr_len_q    <= '0;
            rd_len_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_we_q     <= 1'b0;
            command_q   <= CMDIDLE;
            cmd_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            nack_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            rd_phase_q  <= rd_phase_d;
            addr_q      <= addr_d;
            wr_len_q    <= wr_len_d;
            rd_len_q    <= rd_len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_data_q   <= rd_data_d;
            rd_we_q     <= rd_we_d;
            command_q   <= command_d;
            cmd_valid_q <= cmd_valid_d;
            ready_q     <= ready_d;
            nack_err_q  <= nack_err_d;
        end
    end

    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign rd_data   = rd_data_q;
    assign rd_we     = rd_we_q;
    assign command   = command_q;
    assign cmd_valid = cmd_valid_q;
    assign ready     = ready_q;
    assign nack_err  = nack_err_q;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed bench for i2c_xfer_seq: expected command / rx / read-byte scoreboards
// filled per transaction, drained by a negedge bus model acting as the bit layer.
module tb_i2c_xfer_seq;

    localparam logic [2:0] CMDIDLE  = 3'd0;
    localparam logic [2:0] CMDSTART = 3'd1;
    localparam logic [2:0] CMDSTOP  = 3'd2;
    localparam logic [2:0] CMDBIT0  = 3'd3;
    localparam logic [2:0] CMDBIT1  = 3'd4;
    localparam logic [2:0] CMDRBIT  = 3'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b0;
    logic [6:0] addr = '0;
    logic [2:0] wr_len = '0, rd_len = '0;
    logic [7:0] wr_data;
    logic [2:0] wr_ptr, rd_ptr;
    logic [7:0] rd_data;
    logic       rd_we;
    logic [2:0] command;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic       rx_valid = 1'b0, rx_bit = 1'b0;
    logic       ready, nack_err;

    logic [7:0] wbuf [8];
    logic [7:0] rd_src [4];
    assign wr_data = wbuf[wr_ptr];

    i2c_xfer_seq dut (
        .clk(clk), .reset(reset), .init(init), .addr(addr),
        .wr_len(wr_len), .rd_len(rd_len), .wr_data(wr_data), .wr_ptr(wr_ptr),
        .rd_data(rd_data), .rd_ptr(rd_ptr), .rd_we(rd_we), .command(command),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .rx_valid(rx_valid),
        .rx_bit(rx_bit), .ready(ready), .nack_err(nack_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2:0]  exp_cmd [$];
    logic        rx_q [$];
    logic [10:0] rd_q [$];
    int          n_pushed;
    int          n_xfer = 0;
    bit          stall_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // bit-layer / slave model: handshake, rx responses, read-byte strobes
    bit         rx_wait = 1'b0;
    int         rx_cnt = 0;
    logic       rx_cur = 1'b0;
    bit         stalled = 1'b0;
    logic [2:0] prev_cmd = '0;
    logic [10:0] rd_e;
    always @(negedge clk) begin
        if (!reset) begin
            rx_wait   = 1'b0;
            rx_valid  = 1'b0;
            stalled   = 1'b0;
            cmd_ready = 1'b0;
        end else begin
            rx_valid = 1'b0;
            if (rx_wait) begin
                chk("rbit_wait_no_cmd", cmd_valid, 0);
                if (rx_cnt == 0) begin
                    rx_valid = 1'b1;
                    rx_bit   = rx_cur;
                    rx_wait  = 1'b0;
                end else begin
                    rx_cnt--;
                end
            end
            if (stalled) chk("stall_stable", {cmd_valid, command}, {1'b1, prev_cmd});
            cmd_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cmd_valid && cmd_ready) begin
                n_xfer++;
                chk("cmd_expected", exp_cmd.size() != 0, 1);
                if (exp_cmd.size() != 0) chk("command", command, exp_cmd.pop_front());
                if (command == CMDRBIT) begin
                    chk("rx_expected", rx_q.size() != 0, 1);
                    rx_cur  = (rx_q.size() != 0) ? rx_q.pop_front() : 1'b0;
                    rx_wait = 1'b1;
                    rx_cnt  = stall_mode ? int'($urandom_range(0, 5)) : 0;
                end
            end
            stalled  = cmd_valid && !cmd_ready;
            prev_cmd = command;
            if (rd_we) begin
                chk("rd_we_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    rd_e = rd_q.pop_front();
                    chk("rd_ptr", rd_ptr, rd_e[10:8]);
                    chk("rd_data", rd_data, rd_e[7:0]);
                end
            end
        end
    end

    task automatic push_cmd(input logic [2:0] c);
        exp_cmd.push_back(c);
        n_pushed++;
    endtask

    task automatic push_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) push_cmd(v[i] ? CMDBIT1 : CMDBIT0);
    endtask

    // one transaction: build expectations, request, run to ready (or abort by reset)
    task automatic run_xfer(input string name, input logic [6:0] a, input int wl_in,
                            input int rl_in, input logic nack, input int abort_at);
        int wl, rl, x0, cyc;
        wl = (wl_in > 4) ? 4 : wl_in;
        rl = (rl_in > 4) ? 4 : rl_in;
        n_pushed = 0;
        push_cmd(CMDSTART);
        push_bits({1'b0, a}, 7);
        push_cmd((wl == 0 && rl > 0) ? CMDBIT1 : CMDBIT0);
        push_cmd(CMDRBIT);
        rx_q.push_back(nack);
        if (!nack) begin
            for (int b = 0; b < wl; b++) begin
                push_bits(wbuf[b], 8);
                push_cmd(CMDRBIT);
                rx_q.push_back(1'b0);
            end
            if (rl > 0 && wl > 0) begin
                push_cmd(CMDSTART);
                push_bits({1'b0, a}, 7);
                push_cmd(CMDBIT1);
                push_cmd(CMDRBIT);
                rx_q.push_back(1'b0);
            end
            for (int b = 0; b < rl; b++) begin
                for (int i = 7; i >= 0; i--) begin
                    push_cmd(CMDRBIT);
                    rx_q.push_back(rd_src[b][i]);
                end
                push_cmd((b == rl - 1) ? CMDBIT1 : CMDBIT0);
                rd_q.push_back({3'(b), rd_src[b]});
            end
        end
        push_cmd(CMDSTOP);

        x0     = n_xfer;
        init   = 1'b1;
        addr   = a;
        wr_len = 3'(wl_in);
        rd_len = 3'(rl_in);
        @(negedge clk);
        init = 1'b0;
        chk({name, "_ready_low"}, ready, 0);
        chk({name, "_first_cmd"}, {cmd_valid, command}, {1'b1, CMDSTART});
        chk({name, "_nack_cleared"}, nack_err, 0);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 3000) begin
            if (abort_at > 0 && n_xfer - x0 >= abort_at) break;
            if (cyc == 3) begin
                init   = 1'b1;          // must be ignored while busy
                addr   = ~a;
                wr_len = 3'd1;
                rd_len = 3'd1;
            end else begin
                init = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        init = 1'b0;
        if (abort_at > 0) begin
            chk({name, "_abort_reached"}, n_xfer - x0 >= abort_at, 1);
            chk({name, "_wr_ptr_pre"}, wr_ptr, 1);
            reset = 1'b0;
            #1;
            chk({name, "_rst_cmd_valid"}, cmd_valid, 0);
            chk({name, "_rst_command"}, command, CMDIDLE);
            chk({name, "_rst_ready"}, ready, 1);
            chk({name, "_rst_wr_ptr"}, wr_ptr, 0);
            chk({name, "_rst_rd_ptr"}, rd_ptr, 0);
            exp_cmd.delete();
            rx_q.delete();
            rd_q.delete();
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            return;
        end
        chk({name, "_done"}, ready, 1);
        chk({name, "_cmd_count"}, n_xfer - x0, n_pushed);
        chk({name, "_cmd_q_empty"}, exp_cmd.size(), 0);
        chk({name, "_rx_q_empty"}, rx_q.size(), 0);
        chk({name, "_rd_q_empty"}, rd_q.size(), 0);
        chk({name, "_nack_err"}, nack_err, nack);
        chk({name, "_wr_ptr"}, wr_ptr, nack ? 0 : wl);
        chk({name, "_rd_ptr"}, rd_ptr, nack ? 0 : rl);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) wbuf[i] = 8'h00;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        rd_src[0] = 8'hC3; rd_src[1] = 8'h7E; rd_src[2] = 8'h5A; rd_src[3] = 8'h81;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_command", command, CMDIDLE);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_rd_ptr", rd_ptr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_we", rd_we, 0);
        chk("rst_nack_err", nack_err, 0);
        reset = 1'b1;
        @(negedge clk);

        // plain write, exactly 29 commands
        begin
            int x0;
            x0 = n_xfer;
            run_xfer("write", 7'h50, 2, 0, 1'b0, 0);
            chk("write_29_cmds", n_xfer - x0, 29);
        end

        // address NACK: STOP right after the ACK bit, flag sticks while idle
        run_xfer("addr_nack", 7'h22, 2, 0, 1'b1, 0);
        repeat (5) @(negedge clk);
        chk("nack_err_holds", nack_err, 1);

        // combined write then read with repeated START
        wbuf[0] = 8'h10;
        run_xfer("combined", 7'h3A, 1, 2, 1'b0, 0);
        chk("combined_rd_data_last", rd_data, 8'h7E);

        // probe and read-only
        run_xfer("probe", 7'h5B, 0, 0, 1'b0, 0);
        run_xfer("read_only", 7'h11, 0, 3, 1'b0, 0);

        // length above depth clamps to the buffer depth
        wbuf[0] = 8'hF0; wbuf[1] = 8'h0F; wbuf[2] = 8'h96; wbuf[3] = 8'h69;
        run_xfer("clamp", 7'h7F, 6, 0, 1'b0, 0);

        // backpressure and delayed rx_valid
        stall_mode = 1'b1;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        run_xfer("stall_write", 7'h50, 2, 0, 1'b0, 0);
        wbuf[0] = 8'h10;
        run_xfer("stall_combined", 7'h3A, 1, 2, 1'b0, 0);
        run_xfer("stall_read", 7'h01, 0, 4, 1'b0, 0);
        stall_mode = 1'b0;

        // reset in the middle of the second write byte, then a clean write
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        run_xfer("abort", 7'h50, 2, 0, 1'b0, 22);
        run_xfer("after_abort", 7'h2D, 2, 1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
